// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit adder: one shared CLA4 slice walks the operands LSB nibble first.
// Define SEQADD_SUB_EN to enable A - B (A + ~B + 1) when sub is set at accept.

module cla4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c0_i,
   output logic [3:0] s_o,
   output logic       c4_o
);
   logic [3:0] g, p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = c0_i;
   assign c[1] = g[0] | (p[0] & c0_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0_i);

   assign s_o  = p ^ c[3:0];
   assign c4_o = c[4];
endmodule

module cla_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] bp_q, bp_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] b_acc;
   logic             c_acc;
   logic [IW+1:0]    base;
   logic [3:0]       slice_s;
   logic             slice_c4;

`ifdef SEQADD_SUB_EN
   assign b_acc = sub ? ~b : b;
   assign c_acc = sub ? 1'b1 : cin;
`else
   // sub is a no-op in this build; it is folded away against a constant zero.
   assign b_acc = b;
   assign c_acc = cin | (sub & 1'b0);
`endif

   assign base = {idx_q, 2'b00};

   cla4 u_cla4 (
      .a_i  (a_q[base +: 4]),
      .b_i  (bp_q[base +: 4]),
      .c0_i (carry_q),
      .s_o  (slice_s),
      .c4_o (slice_c4)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      bp_d    = bp_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               bp_d    = b_acc;
               carry_d = c_acc;
               idx_d   = '0;
               sum_d   = '0;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sum_d[base +: 4] = slice_s;
            carry_d          = slice_c4;
            idx_d            = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               cout_d  = slice_c4;
               ovf_d   = (a_q[WIDTH-1] == bp_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         bp_q    <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         bp_q    <= bp_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: WIDTH=16 instance plus a WIDTH=4 instance.
// Expectations for the sub case follow SEQADD_SUB_EN.

module tb_cla_seq_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        start, cin, sub;
   logic [15:0] a, b;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic        start4, cin4, sub4;
   logic [3:0]  a4, b4;
   logic        busy4, done4, cout4, ovf4;
   logic [3:0]  sum4;

   int checks = 0;
   int errors = 0;
   int cnt;

   always #5 clk = ~clk;

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   cla_seq_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge; returns at the negedge where done should be high.
   task automatic wait_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic launch(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
      a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 0; a = 0; b = 0; cin = 0; sub = 0;
      start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sum4", sum4, 0);

      // 0x1234 + 0x4321
      launch(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_busy(cnt);
      chk("add1_busy_cycles", cnt, 4);
      chk("add1_done", done, 1);
      chk("add1_sum", sum, 16'h5555);
      chk("add1_cout", cout, 0);
      chk("add1_ovf", ovf, 0);
      @(negedge clk);
      chk("add1_done_single", done, 0);
      chk("add1_sum_hold", sum, 16'h5555);

      // 0xFFFF + 0x0001 wraps
      launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_busy(cnt);
      chk("add2_done", done, 1);
      chk("add2_sum", sum, 16'h0000);
      chk("add2_cout", cout, 1);
      chk("add2_ovf", ovf, 0);
      @(negedge clk);

      // 0x7FFF + 0 + cin signed overflow
      launch(16'h7FFF, 16'h0000, 1'b1, 1'b0);
      wait_busy(cnt);
      chk("add3_sum", sum, 16'h8000);
      chk("add3_cout", cout, 0);
      chk("add3_ovf", ovf, 1);
      @(negedge clk);

      // 5 - 7 (or 5 + 7 when subtraction is not built)
      launch(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_busy(cnt);
`ifdef SEQADD_SUB_EN
      chk("sub_sum", sum, 16'hFFFE);
`else
      chk("sub_sum", sum, 16'h000C);
`endif
      chk("sub_cout", cout, 0);
      chk("sub_ovf", ovf, 0);
      @(negedge clk);

      // start pulsed mid-RUN is ignored
      launch(16'h1234, 16'h4321, 1'b0, 1'b0);
      @(negedge clk);
      a = 16'h0F0F; b = 16'h0101; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_busy(cnt);
      chk("ign_busy_cycles", cnt, 2);
      chk("ign_sum", sum, 16'h5555);
      @(negedge clk);
      chk("ign_no_restart", busy, 0);
      chk("ign_no_done", done, 0);

      // start held across done: second accept in DONE cycle, done spacing 5
      a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 16'h7FFF; b = 16'h0000; cin = 1'b1;
      wait_busy(cnt);
      chk("b2b_first_done", done, 1);
      chk("b2b_first_sum", sum, 16'h0000);
      chk("b2b_first_cout", cout, 1);
      @(negedge clk);
      start = 1'b0;
      cnt = 1;
      while (done !== 1'b1 && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      chk("b2b_spacing", cnt, 5);
      chk("b2b_second_sum", sum, 16'h8000);
      chk("b2b_second_ovf", ovf, 1);
      @(negedge clk);

      // reset in 2nd RUN cycle aborts
      launch(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      chk("abort_ovf", ovf, 0);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) cnt++;
      end
      chk("abort_no_done", cnt, 0);

      // WIDTH=4: 9 + 8
      a4 = 4'h9; b4 = 4'h8; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      chk("w4_busy", busy4, 1);
      @(negedge clk);
      chk("w4_busy_end", busy4, 0);
      chk("w4_done", done4, 1);
      chk("w4_sum", sum4, 4'h1);
      chk("w4_cout", cout4, 1);
      chk("w4_ovf", ovf4, 1);
      @(negedge clk);
      chk("w4_done_single", done4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
